// File: rtl/mem_copy_master.sv
// Block-copy bus master: copies len 32-bit words from src to dst over a shared
// memory port, one read and one write per word, arbitrated by bus_req/bus_gnt.
module mem_copy_master #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              irq_en,
  input  logic              irq_clr,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       Write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       Read_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              irqout,
  output logic [LEN_W-1:0]  words_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       buffer;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      remaining  <= '0;
      buffer     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      irqout     <= 1'b0;
      words_done <= '0;
    end else begin
      done <= 1'b0;
      // A set in FIN below overrides this clear in the same cycle.
      if (irq_clr) irqout <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            src        <= src_addr;
            dst        <= dst_addr;
            remaining  <= len;
            err        <= 1'b0;
            words_done <= '0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (remaining == '0) begin
            state <= FIN;
          end else begin
            state <= RD;
          end
        end

        RD: begin
          if (bus_gnt) begin
            buffer <= Read_data;
            state  <= WR;
          end
        end

        WR: begin
          if (bus_gnt) begin
            src        <= src + ADDR_W'(4);
            dst        <= dst + ADDR_W'(4);
            remaining  <= remaining - LEN_W'(1);
            words_done <= words_done + LEN_W'(1);
            state      <= (remaining == LEN_W'(1)) ? FIN : RD;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          done  <= ~err;
          if (irq_en) irqout <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Strobes gate on bus_gnt combinationally so a dropped grant never leaves a
  // half-performed access; the FSM only advances on granted cycles.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    bus_req    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    case (state)
      RD: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          MemRead = 1'b1;
          Address = src;
        end
      end
      WR: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          MemWrite   = 1'b1;
          Address    = dst;
          Write_data = buffer;
        end
      end
      default: ;
    endcase
  end

endmodule
